// File: rtl/pwm_led_bank.sv
// pwm_led_bank: multi-channel LED PWM generator. A single free-running period
// counter is shared by all channels; each channel has a host-written shadow
// duty register and an active duty register. The active register only takes
// the shadow value at period boundaries, or at any time while disabled, so a
// duty change never cuts a PWM pulse short.
// Optional feature macro PWM_FADE_EN: at each boundary the active duty moves
// toward the shadow duty by FADE_STEP instead of jumping to it.
module pwm_led_bank #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int CHW       = 2,
  parameter int FADE_STEP = 1
) (
  input  logic                SysClk,
  input  logic                Reset,
  input  logic                Enable,
  input  logic                WrEn,
  input  logic [CHW-1:0]      WrChan,
  input  logic [WIDTH-1:0]    WrDuty,
  output logic [CHANNELS-1:0] PWM,
  output logic                PeriodStart
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_d [CHANNELS];
  logic [WIDTH-1:0]    active_q [CHANNELS];
  logic [WIDTH-1:0]    active_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_start_q, period_start_d;
  logic                at_max;

  // Move cur one step of FADE_STEP toward tgt without overshooting. The
  // arithmetic is one bit wider than the duty so it cannot wrap at 0 or MAX.
  function automatic logic [WIDTH-1:0] fade_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
    logic [WIDTH:0] cur_x;
    logic [WIDTH:0] tgt_x;
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] res_x;
    cur_x  = {1'b0, cur};
    tgt_x  = {1'b0, tgt};
    step_x = (WIDTH+1)'(FADE_STEP);
    if (tgt_x > cur_x) begin
      res_x = ((tgt_x - cur_x) <= step_x) ? tgt_x : (cur_x + step_x);
    end else if (cur_x > tgt_x) begin
      res_x = ((cur_x - tgt_x) <= step_x) ? tgt_x : (cur_x - step_x);
    end else begin
      res_x = cur_x;
    end
    return WIDTH'(res_x);
  endfunction

  assign at_max = (cnt_q == MAX);

  // Period counter and compare: outputs are registered, so they lag cnt by one cycle.
  always_comb begin
    cnt_d          = Enable ? (cnt_q + WIDTH'(1)) : '0;
    period_start_d = Enable && (cnt_q == '0);
    pwm_d          = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = Enable && ((active_q[i] == MAX) || (cnt_q < active_q[i]));
    end
  end

  // Host writes land in the shadow register; out-of-range channels match nothing.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (WrEn && (WrChan == CHW'(i))) begin
        shadow_d[i] = WrDuty;
      end
    end
  end

  // Active duty update: only at the wrap edge (or continuously while idle),
  // always from the shadow value held before this edge.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      active_d[i] = active_q[i];
`ifdef PWM_FADE_EN
      if (Enable && at_max) begin
        active_d[i] = fade_toward(active_q[i], shadow_q[i]);
      end
`else
      if (!Enable || at_max) begin
        active_d[i] = shadow_q[i];
      end
`endif
    end
  end

  // State registers; reset clears counter, duty registers and outputs.
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      cnt_q          <= '0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      cnt_q          <= cnt_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign PWM         = pwm_q;
  assign PeriodStart = period_start_q;

endmodule
